// File: rtl/div_arbiter_if.sv
// Signal bundle around div_arbiter: requester-side request/response lines
// plus the start/done handshake to the shared divider.
interface div_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int N_REQ  = 4
);
    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] dividend;
    logic [N_REQ*DATA_W-1:0] divisor;
    logic [N_REQ-1:0]        ack;
    logic [N_REQ-1:0]        res_valid;
    logic [DATA_W-1:0]       quotient;
    logic [DATA_W-1:0]       remainder;
    logic                    busy;
    logic                    div_start;
    logic [DATA_W-1:0]       div_dividend;
    logic [DATA_W-1:0]       div_divisor;
    logic                    div_done;
    logic [DATA_W-1:0]       div_quotient;
    logic [DATA_W-1:0]       div_remainder;

    modport master (
        input  req, dividend, divisor, div_done, div_quotient, div_remainder,
        output ack, res_valid, quotient, remainder, busy,
               div_start, div_dividend, div_divisor
    );

    modport slave (
        output req, dividend, divisor, div_done, div_quotient, div_remainder,
        input  ack, res_valid, quotient, remainder, busy,
               div_start, div_dividend, div_divisor
    );
endinterface

// File: rtl/div_arbiter.sv
// Round-robin scheduler sharing one sequential divider among N_REQ requesters;
// divide-by-zero is answered locally without starting the divider.
module div_arbiter #(
    parameter int DATA_W = 32,
    parameter int N_REQ  = 4
) (
    input logic           clk,
    input logic           rst,
    div_arbiter_if.master bus
);
    localparam int IDX_W = $clog2(N_REQ);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] ptr, gnt, winner;
    logic             any_req, zero_div;

    // First set request bit scanning ptr, ptr+1, ... modulo N_REQ.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                 input logic [IDX_W-1:0] p);
        logic [IDX_W-1:0] pick;
        int               idx;
        pick = p;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = int'(p) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (r[idx]) pick = IDX_W'(idx);
        end
        return pick;
    endfunction

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] g);
        return (g == IDX_W'(N_REQ - 1)) ? '0 : g + 1'b1;
    endfunction

    assign winner   = rr_pick(bus.req, ptr);
    assign any_req  = |bus.req;
    assign zero_div = (bus.div_divisor == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ISSUE;
            ISSUE:   state_nxt = zero_div ? RESP : WAIT;
            WAIT:    if (bus.div_done) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.ack       = '0;
        bus.res_valid = '0;
        bus.div_start = 1'b0;
        bus.busy      = (state != IDLE);
        case (state)
            ISSUE: begin
                bus.ack[gnt]  = 1'b1;
                bus.div_start = !zero_div;
            end
            RESP:    bus.res_valid[gnt] = 1'b1;
            default: ;
        endcase
    end

    // Operands stay latched from ISSUE through WAIT; div_done is only heeded in WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr              <= '0;
            gnt              <= '0;
            bus.div_dividend <= '0;
            bus.div_divisor  <= '0;
            bus.quotient     <= '0;
            bus.remainder    <= '0;
        end else begin
            case (state)
                IDLE: if (any_req) begin
                    gnt              <= winner;
                    bus.div_dividend <= bus.dividend[int'(winner)*DATA_W +: DATA_W];
                    bus.div_divisor  <= bus.divisor[int'(winner)*DATA_W +: DATA_W];
                end
                ISSUE: if (zero_div) begin
                    bus.quotient  <= '1;
                    bus.remainder <= bus.div_dividend;
                end
                WAIT: if (bus.div_done) begin
                    bus.quotient  <= bus.div_quotient;
                    bus.remainder <= bus.div_remainder;
                end
                RESP:    ptr <= next_idx(gnt);
                default: ;
            endcase
        end
    end
endmodule
